// File: rtl/cls7_pkg.sv
// Shared types and sizes for the 7-input classification harness.
package cls7_pkg;
    localparam int N_IN    = 7;
    localparam int TT_W    = 128;
    localparam int ONSET_W = 8;

    localparam logic [N_IN-1:0] X_LAST = '1;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

    typedef logic [TT_W-1:0] sig_t;

    // One slot of the capture pipeline: which x index f_in will belong to.
    typedef struct packed {
        logic            vld;
        logic [N_IN-1:0] idx;
    } cap_t;
endpackage

// File: rtl/tt_cap_pipe.sv
// LAT-deep {valid, index} delay line aligning each presented x with its f_in.
// Latency LAT cycles (combinational pass-through when LAT=0); no backpressure, flush clears all slots.
module tt_cap_pipe
    import cls7_pkg::*;
#(
    parameter int LAT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  cap_t in_cap,
    output cap_t out_cap
);

    generate
        if (LAT == 0) begin : g_wire
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, rst_n, flush};
            assign out_cap   = in_cap;
        end else begin : g_pipe
            cap_t stg_q [LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LAT; i++) stg_q[i] <= '0;
                end else if (flush) begin
                    for (int i = 0; i < LAT; i++) stg_q[i] <= '0;
                end else begin
                    stg_q[0] <= in_cap;
                    for (int i = 1; i < LAT; i++) stg_q[i] <= stg_q[i-1];
                end
            end

            assign out_cap = stg_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/tt_sweep_collector.sv
// Sweeps x over 0..127, captures f_in into a 128-bit truth table, counts onset and compares to expected.
// Latency start-to-done 129+LAT cycles; no backpressure, start ignored while busy, abort cancels a sweep.
module tt_sweep_collector
    import cls7_pkg::*;
#(
    parameter int LAT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [TT_W-1:0]    expected,
    output logic [N_IN-1:0]    x,
    input  logic               f_in,
    output logic               busy,
    output logic               done,
    output logic [TT_W-1:0]    tt,
    output logic [ONSET_W-1:0] onset,
    output logic               match
);

    state_t              state_q, state_d;
    logic [N_IN-1:0]     x_q;
    sig_t                tt_q, exp_q;
    logic [ONSET_W-1:0]  onset_q;
    logic                match_q, done_q;
    logic                fin_q;
    logic                start_ok, kill, final_cap;
    cap_t                in_cap, head;

    // fin_q marks the one cycle between the last capture and done; it counts as busy.
    assign busy      = (state_q != IDLE) || fin_q;
    assign start_ok  = start && (state_q == IDLE) && !fin_q;
    assign kill      = abort && busy;
    assign final_cap = head.vld && (head.idx == X_LAST);

    assign in_cap.vld = (state_q == SWEEP);
    assign in_cap.idx = x_q;

    tt_cap_pipe #(.LAT(LAT)) u_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (kill),
        .in_cap  (in_cap),
        .out_cap (head)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) state_d = SWEEP;
            end
            SWEEP: begin
                if (abort || final_cap) state_d = IDLE;
                else if (x_q == X_LAST)  state_d = DRAIN;
            end
            DRAIN: begin
                if (abort || final_cap) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            tt_q    <= '0;
            exp_q   <= '0;
            onset_q <= '0;
            match_q <= 1'b0;
            done_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (start_ok) begin
                x_q     <= '0;
                tt_q    <= '0;
                onset_q <= '0;
                match_q <= 1'b0;
                exp_q   <= expected;
                fin_q   <= 1'b0;
            end else if (kill) begin
                // Partial tt/onset are kept for inspection; nothing is captured this edge.
                fin_q   <= 1'b0;
                match_q <= 1'b0;
            end else begin
                if ((state_q == SWEEP) && (x_q != X_LAST)) x_q <= x_q + 7'd1;
                if (head.vld) begin
                    tt_q[head.idx] <= f_in;
                    onset_q        <= onset_q + {{(ONSET_W-1){1'b0}}, f_in};
                end
                fin_q <= final_cap;
                if (fin_q) begin
                    done_q  <= 1'b1;
                    match_q <= (tt_q == exp_q);
                end
            end
        end
    end

    assign x     = x_q;
    assign tt    = tt_q;
    assign onset = onset_q;
    assign match = match_q;
    assign done  = done_q;

endmodule

// File: doc/tt_sweep_collector.md
# tt_sweep_collector

Sequential truth-table extractor that sits directly upstream of a 7-input majority-logic classification function. It drives every input combination x[6:0] = 0..127 into the function, samples the function's 1-bit output, and assembles the 128-bit truth-table signature. It also counts onset minterms and compares the signature with an expected value captured at start. It is the harness stage that turns each combinational classification netlist into the hex signature used to index the function class.

## Interface
- LAT, default 0: cycles from x changing to a valid f_in. 0 means a purely combinational function; legal range 0..7.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a sweep; honoured only in IDLE
- abort  in  1  cancel the sweep; honoured in SWEEP/DRAIN
- expected  in  128  reference signature, sampled on accepted start
- x  out  7  input vector driven to the function (registered)
- f_in  in  1  function output for the x presented LAT cycles earlier
- busy  out  1  high in SWEEP and DRAIN
- done  out  1  one-cycle pulse when tt/match/onset are final
- tt  out  128  truth table; tt[i] = f(x=i), x0 = index LSB; tt[127] is the first hex digit of the signature
- onset  out  8  number of 1 bits in tt, 0..128
- match  out  1  tt == expected; valid from done, held until next start

## Operation
- Reset values:
  - state = IDLE
  - x = 0, tt = 0, onset = 0
  - busy = 0, done = 0, match = 0
  - expected register = 0
  - capture pipeline cleared
- States: IDLE -> SWEEP -> DRAIN -> IDLE.
- IDLE:
  - An accepted start (start=1) moves to SWEEP with x=0.
  - It clears tt and onset, clears match, and latches expected.
- SWEEP:
  - x increments by 1 every cycle.
  - The index of each presented x enters a LAT-deep valid/index pipeline.
  - After x=127 has been presented the state goes to DRAIN. x holds at 127; it does not wrap to 0.
- DRAIN:
  - Lasts until the final capture, for LAT cycles.
  - With LAT=0, DRAIN is skipped and SWEEP returns directly to IDLE.
- Capture: whenever the pipeline head is valid with index i:
  - tt[i] <= f_in
  - onset <= onset + f_in, with 8-bit arithmetic; the maximum of 128 cannot overflow.
- Completion:
  - On the cycle after the capture of index 127: done=1 for exactly one cycle, match = (final tt == latched expected), and the state returns to IDLE.
  - tt, onset and match then hold until the next accepted start.
- start while busy: ignored, with no effect on the sweep.
- start on the same cycle done is high: accepted, since the state is already IDLE in that cycle.
- abort:
  - Returns to IDLE on the next edge and flushes the pipeline.
  - done is not pulsed. tt and onset hold their partial values. match = 0.
  - abort takes priority over the final capture.
- start and abort together in IDLE: start wins, because abort is ignored in IDLE.
- Asynchronous reset mid-sweep: every output returns to its reset value immediately, and no done is produced.

## Timing
- Start accepted at edge E:
  - x = k after edge E+k, for k = 0..127.
  - busy = 1 from after edge E through the cycle before done.
- Index k is captured at edge E+k+1+LAT.
- done is high in the cycle after edge E+129+LAT.
- Start-to-done latency is 129+LAT cycles; a new start can be accepted in that done cycle.
- f_in must be valid at the clock edge LAT cycles after the corresponding x update. The block adds no extra input register.

## Structure
- Shared package cls7_pkg:
  - N_IN = 7, TT_W = 128, ONSET_W = 8.
  - State enum {IDLE, SWEEP, DRAIN}.
  - Signature type logic [TT_W-1:0].
- One sub-module, tt_cap_pipe: a LAT-deep shift register of {valid, index[6:0]}, with a flush input. For LAT=0 it is a pass-through wire.
- The FSM, x counter, tt/onset registers and comparator live in the top.

## Test plan
- Connect a 3-input majority of x0,x1,x2 and set LAT=0. Expect tt = 128'hE8E8…E8 (16 bytes of E8), onset = 64, match = 1 with expected equal to that value, and done exactly 129 cycles after start.
- Constant f_in = 1 with expected = 0. Expect tt = all ones, onset = 128 with no overflow, and match = 0.
- LAT = 3 with the majority function behind a 3-stage delay. Expect the same tt as the first scenario and done at 132 cycles.
- Assert abort at x = 50. Expect no done pulse, state back in IDLE, tt[49:0] filled, and match = 0. A following start must then produce a full, correct sweep.
- Pulse start at x = 10 during a sweep. Expect it to be ignored and the sweep to continue. A start pulsed in the done cycle must begin a new sweep with x = 0 on the next cycle.
- Assert rst_n low at x = 70. Expect all outputs zero immediately and busy = 0. After release, the block stays idle until start.
